// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side bundle of the FIFO write arbiter: requests and words in,
// grants, FIFO write port and occupancy out.
interface fifo_wr_arbiter_if #(
   parameter int WIDTH     = 8,
   parameter int NREQ      = 4,
   parameter int LVL_WIDTH = 5
);
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] wdata_in;
   logic                  fifo_rd_en;
   logic [NREQ-1:0]       gnt;
   logic                  fifo_wr_en;
   logic [WIDTH-1:0]      fifo_wdata;
   logic [LVL_WIDTH-1:0]  level;
   logic                  busy;

   modport master (
      output req, wdata_in, fifo_rd_en,
      input  gnt, fifo_wr_en, fifo_wdata, level, busy
   );

   modport slave (
      input  req, wdata_in, fifo_rd_en,
      output gnt, fifo_wr_en, fifo_wdata, level, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of one synchronous FIFO, with bounded
// bursts per owner and a private credit counter so the FIFO is never overfilled.
module fifo_wr_arbiter #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 16,
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 4,
   parameter int LVL_WIDTH = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst,
   fifo_wr_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(NREQ);
   localparam int BC_W  = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [PTR_W-1:0]      owner_q, owner_d;
   logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [BC_W-1:0]       burst_cnt_q, burst_cnt_d;
   logic [NREQ-1:0]       gnt_q, gnt_d;
   logic                  wr_en_q, wr_en_d;
   logic [WIDTH-1:0]      wdata_q, wdata_d;
   logic [LVL_WIDTH-1:0]  level_q, level_d;

   logic                  space;
   logic                  rd_ok;
   logic [PTR_W-1:0]      owner_inc;
   logic [PTR_W-1:0]      start;
   logic [NREQ-1:0]       req_rot;
   logic                  found;
   logic [PTR_W-1:0]      offset;
   logic [PTR_W-1:0]      winner;
   logic                  issue;
   logic [PTR_W-1:0]      issue_idx;
   logic [WIDTH-1:0]      word [NREQ];

   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a,
                                                 input logic [PTR_W-1:0] b);
      logic [PTR_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= (PTR_W+1)'(NREQ)) s = s - (PTR_W+1)'(NREQ);
      return s[PTR_W-1:0];
   endfunction

   // Credit check uses the in-flight write too, since the FIFO's own full flag lags.
   assign space     = ({1'b0, level_q} + {{LVL_WIDTH{1'b0}}, wr_en_q}) < (LVL_WIDTH+1)'(DEPTH);
   assign rd_ok     = bus.fifo_rd_en && (level_q != '0);
   assign owner_inc = wrap_add(owner_q, PTR_W'(1));
   assign start     = (state_q == BURST) ? owner_inc : rr_ptr_q;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         assign req_rot[gi] = bus.req[wrap_add(start, PTR_W'(gi))];
         assign word[gi]    = bus.wdata_in[gi*WIDTH +: WIDTH];
      end
   endgenerate

   always_comb begin
      found  = 1'b0;
      offset = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            found  = 1'b1;
            offset = PTR_W'(i);
         end
      end
      winner = wrap_add(start, offset);
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      gnt_d       = '0;
      wr_en_d     = 1'b0;
      wdata_d     = wdata_q;
      issue       = 1'b0;
      issue_idx   = owner_q;
      case (state_q)
         IDLE: begin
            if (found && space) begin
               issue       = 1'b1;
               issue_idx   = winner;
               owner_d     = winner;
               burst_cnt_d = BC_W'(1);
               state_d     = BURST;
            end
         end
         BURST: begin
            if (bus.req[owner_q] && space && (burst_cnt_q < BC_W'(MAX_BURST))) begin
               issue       = 1'b1;
               burst_cnt_d = burst_cnt_q + 1'b1;
            end else begin
               // Release re-arbitrates from owner+1 in the same cycle: no bubble.
               rr_ptr_d = owner_inc;
               if (found && space) begin
                  issue       = 1'b1;
                  issue_idx   = winner;
                  owner_d     = winner;
                  burst_cnt_d = BC_W'(1);
               end else begin
                  burst_cnt_d = '0;
                  state_d     = IDLE;
               end
            end
         end
      endcase
      if (issue) begin
         gnt_d   = NREQ'(1) << issue_idx;
         wr_en_d = 1'b1;
         wdata_d = word[issue_idx];
      end
   end

   always_comb begin
      level_d = level_q;
      case ({wr_en_q, rd_ok})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
         gnt_q       <= '0;
         wr_en_q     <= 1'b0;
         wdata_q     <= '0;
         level_q     <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         gnt_q       <= gnt_d;
         wr_en_q     <= wr_en_d;
         wdata_q     <= wdata_d;
         level_q     <= level_d;
      end
   end

   assign bus.gnt        = gnt_q;
   assign bus.fifo_wr_en = wr_en_q;
   assign bus.fifo_wdata = wdata_q;
   assign bus.level      = level_q;
   assign bus.busy       = (state_q == BURST);
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one fifo_sync instance between NREQ producers.
- Owns the FIFO write port (wr_en/wdata). Keeps its own credit counter, so it never writes into a full FIFO and never relies on the FIFO's registered full flag, which lags by one cycle.
- Supports bounded bursts: one owner may write up to MAX_BURST consecutive words before being forced to re-arbitrate.

Parameters:
- WIDTH, 8, data word width; matches the FIFO WIDTH.
- DEPTH, 16, FIFO depth; sets the credit limit.
- NREQ, 4, number of requesters (2..8).
- MAX_BURST, 4, maximum consecutive writes per ownership (1..DEPTH).
- LVL_WIDTH, $clog2(DEPTH)+1, width of the level counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  NREQ  req[k]=1 means requester k presents a valid word.
- wdata_in  input  NREQ*WIDTH  requester k word on bits [k*WIDTH +: WIDTH].
- fifo_rd_en  input  1  consumer read strobe, the same signal that drives the FIFO rd_en.
- gnt  output  NREQ  registered one-hot; gnt[k]=1 means requester k's word was taken at the previous edge.
- fifo_wr_en  output  1  registered, drives FIFO wr_en.
- fifo_wdata  output  WIDTH  registered, drives FIFO wdata.
- level  output  LVL_WIDTH  registered count of words written into the FIFO and not yet read.
- busy  output  1  high while the FSM is in BURST.

Behaviour:
- Reset (async, immediate): gnt=0, fifo_wr_en=0, fifo_wdata=0, level=0, busy=0, state=IDLE, burst_cnt=0, owner=0, rr_ptr=0.
- space = (level + fifo_wr_en) < DEPTH, evaluated combinationally each cycle from registered values.
- Arbitration (combinational):
  - Search req starting at index rr_ptr, wrapping modulo NREQ.
  - The first set bit wins.
  - No set bit means no winner.
- Write issue at an edge:
  - Conditions: a winner w exists (or the owner continues) and space=1.
  - Next cycle: gnt=one-hot(w), fifo_wr_en=1, fifo_wdata=wdata_in slice w sampled at that edge.
  - Otherwise next cycle: gnt=0, fifo_wr_en=0, fifo_wdata holds its previous value.
  - Latency: one cycle from the sampling edge to fifo_wr_en. The FIFO stores the word at the following edge.
- Requester handshake:
  - Hold req and data stable until gnt[k] is seen.
  - During the gnt[k] cycle, either present the next word or drop req.
  - A word is never taken twice.
- FSM states:
  - IDLE:
    - If a winner exists and space=1: issue write, owner=w, burst_cnt=1, go to BURST.
    - Otherwise stay in IDLE.
  - BURST, continue case:
    - Condition: req[owner]=1 and space=1 and burst_cnt<MAX_BURST.
    - Action: issue write for owner, burst_cnt+1.
  - BURST, release (any other case):
    - rr_ptr=(owner+1) mod NREQ.
    - Re-arbitrate in the same cycle with the new rr_ptr.
    - If a winner exists and space=1: issue write, owner=w, burst_cnt=1, stay in BURST. No bubble; the old owner has lowest priority.
    - Otherwise go to IDLE.
- Level counter:
  - +1 when fifo_wr_en=1 (the FIFO write edge).
  - -1 when fifo_rd_en=1 and level>0.
  - Both at once: unchanged.
  - fifo_rd_en with level=0 is ignored; level never underflows.
  - level never exceeds DEPTH.
- Boundaries:
  - At level+fifo_wr_en=DEPTH, no issue occurs and a burst ends.
  - A read that frees a slot allows an issue at the next edge.
  - rr_ptr wraps from NREQ-1 to 0.
  - req[owner] deasserted mid-burst ends the burst at that edge.
  - Reset mid-burst clears everything at once; a pending fifo_wr_en is dropped.

Test Plan (NREQ=4, DEPTH=16, MAX_BURST=4):
- Reset, then req[2]=1 for 6 words, no reads -> gnt[2] high for 6 consecutive cycles starting 1 cycle after the first sampling edge, fifo_wdata equals the 6 words in order, level ends at 6, busy high throughout, then low.
- req=4'b1111 held continuously, with reads every cycle -> grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0…, no idle cycle between owners.
- req[0] held, no reads -> exactly 16 writes, level=16, fifo_wr_en=0 afterwards, no FIFO wr_err. A single fifo_rd_en pulse gives level=15, one further write, and level back to 16.
- Level at 5 with fifo_wr_en=1 and fifo_rd_en=1 in the same cycle -> level stays 5. fifo_rd_en pulsed at level=0 -> level stays 0.
- req[1] dropped after 2 words while req[3]=1 -> owner 1 releases, gnt[3] is granted at the next edge with no bubble, rr_ptr=2.
- rst asserted asynchronously mid-burst (owner 2, burst_cnt=3) -> gnt, fifo_wr_en, level and busy go to 0 immediately. After rst falls with req[3]=1 and req[2]=1, the first grant goes to 2, since rr_ptr=0 and index 2 is reached before 3.
